// File: rtl/armaria_regbank_pkg.sv
// Shared types and bank command codes for the register-bank write path.
package armaria_regbank_pkg;

  typedef enum logic [2:0] {
    WB_NONE        = 3'd0,
    WB_ALU         = 3'd1,
    WB_LOAD        = 3'd2,
    WB_LOAD_DIRECT = 3'd3,
    WB_TRAP        = 3'd4,
    WB_SOFT_RESET  = 3'd5,
    WB_RETURN      = 3'd6
  } wb_kind_t;

  localparam logic [2:0] CTRL_NONE         = 3'd0;
  localparam logic [2:0] CTRL_ALU          = 3'd1;
  localparam logic [2:0] CTRL_SOFT_RESET   = 3'd2;
  localparam logic [2:0] CTRL_LOAD_CAPTURE = 3'd3;
  localparam logic [2:0] CTRL_ENTER_PRIV   = 3'd4;
  localparam logic [2:0] CTRL_LOAD_COMMIT  = 3'd5;
  localparam logic [2:0] CTRL_LOAD_DIRECT  = 3'd6;

  typedef enum logic [1:0] {
    SEQ_IDLE        = 2'd0,
    SEQ_LOAD_WAIT   = 2'd1,
    SEQ_LOAD_COMMIT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/load_timeout_counter.sv
// Counts cycles spent waiting for memory; flags the cycle in which the limit is reached.
module load_timeout_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       count,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clear)
      r_count <= 8'd0;
    else if (count && r_count != 8'hFF)
      r_count <= r_count + 8'd1;
  end

  // r_count holds completed wait cycles, so the current cycle is number r_count+1
  assign expired = count && (({1'b0, r_count} + 9'd1) >= {1'b0, limit});

endmodule

// File: rtl/regbank_write_sequencer.sv
// Turns decoded write-back requests into register-bank enable/control/dest commands.
// Optional LOAD_WAIT timeout is compiled in with `define REGBANK_SEQ_TIMEOUT_EN.
module regbank_write_sequencer
  import armaria_regbank_pkg::*;
#(
  parameter int REGISTER_LENGTH = 32,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wb_valid,
  output logic       wb_ready,
  input  logic [2:0] wb_kind,
  input  logic [3:0] wb_dest,
  input  logic       mem_ack,
  output logic       bank_enable,
  output logic [2:0] bank_control,
  output logic [3:0] bank_dest,
  output logic       privileged_mode,
  output logic       busy,
  output logic       timeout_error
);

  generate
    if (REGISTER_LENGTH < 1) begin : g_bad_width
      $error("REGISTER_LENGTH must be positive");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..255");
    end
  endgenerate

  seq_state_t r_state;
  logic       r_enable;
  logic [2:0] r_control;
  logic [3:0] r_dest;
  logic       r_priv;
  logic       w_expired;

`ifdef REGBANK_SEQ_TIMEOUT_EN
  logic r_timeout_error;

  load_timeout_counter u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (r_state != SEQ_LOAD_WAIT),
    .count   (r_state == SEQ_LOAD_WAIT),
    .limit   (8'(TIMEOUT_CYCLES)),
    .expired (w_expired)
  );

  assign timeout_error = r_timeout_error;
`else
  assign w_expired     = 1'b0;
  assign timeout_error = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= SEQ_IDLE;
      r_enable  <= 1'b0;
      r_control <= CTRL_NONE;
      r_dest    <= 4'd0;
      r_priv    <= 1'b0;
`ifdef REGBANK_SEQ_TIMEOUT_EN
      r_timeout_error <= 1'b0;
`endif
    end else begin
      r_enable  <= 1'b0;
      r_control <= CTRL_NONE;
      case (r_state)
        SEQ_IDLE: begin
          // NONE and the illegal kind still pulse enable so the bank advances PC/SP
          if (wb_valid) begin
            r_enable <= 1'b1;
            case (wb_kind_t'(wb_kind))
              WB_ALU: begin
                r_control <= CTRL_ALU;
                r_dest    <= wb_dest;
              end
              WB_LOAD: begin
                r_control <= CTRL_LOAD_CAPTURE;
                r_dest    <= wb_dest;
                r_state   <= SEQ_LOAD_WAIT;
              end
              WB_LOAD_DIRECT: r_control <= CTRL_LOAD_DIRECT;
              WB_TRAP: begin
                r_control <= CTRL_ENTER_PRIV;
                r_priv    <= 1'b1;
              end
              WB_SOFT_RESET: begin
                r_control <= CTRL_SOFT_RESET;
                r_priv    <= 1'b0;
              end
              WB_RETURN: r_priv <= 1'b0;
              default: ;
            endcase
          end
        end
        SEQ_LOAD_WAIT: begin
          // ack beats the timeout when both land in the same cycle
          if (mem_ack) begin
            r_enable  <= 1'b1;
            r_control <= CTRL_LOAD_COMMIT;
            r_state   <= SEQ_LOAD_COMMIT;
          end else if (w_expired) begin
            r_state <= SEQ_IDLE;
`ifdef REGBANK_SEQ_TIMEOUT_EN
            r_timeout_error <= 1'b1;
`endif
          end
        end
        SEQ_LOAD_COMMIT: r_state <= SEQ_IDLE;
        default:         r_state <= SEQ_IDLE;
      endcase
    end
  end

  assign wb_ready        = (r_state == SEQ_IDLE);
  assign busy            = (r_state != SEQ_IDLE);
  assign bank_enable     = r_enable;
  assign bank_control    = r_control;
  assign bank_dest       = r_dest;
  assign privileged_mode = r_priv;

endmodule

// File: doc/regbank_write_sequencer.md
# regbank_write_sequencer

Issues the per-cycle `enable`/`control`/destination commands that drive the register bank's negedge write port. It accepts one decoded write-back request at a time and converts it into the bank's command codes, including the two-phase buffered load (capture code 3, then commit code 5) and privileged-mode entry. It sits between the instruction decoder and the register bank, and tracks the privileged-mode flag that the bank uses to select its stack pointer.

## Interface
- `REGISTER_LENGTH`, 32: data width; used only for width consistency checks.
- `TIMEOUT_CYCLES`, 15: maximum number of cycles spent in LOAD_WAIT before a timeout; only meaningful with the timeout feature enabled. Range 1..255.

Ports (reset reset, synchronous, active-high; clock clock):
- `clock` in 1: rising-edge clock. All state and outputs are registered on posedge.
- `reset` in 1: synchronous, active-high.
- `wb_valid` in 1: decoder presents a request.
- `wb_ready` out 1: the sequencer accepts a request this cycle.
- `wb_kind` in 3: request kind. 0 NONE, 1 ALU, 2 LOAD, 3 LOAD_DIRECT, 4 TRAP, 5 SOFT_RESET, 6 RETURN; 7 is illegal.
- `wb_dest` in 4: destination register index.
- `mem_ack` in 1: memory data is valid on the bank's `data_from_memory` at the next posedge.
- `bank_enable` out 1: bank write enable.
- `bank_control` out 3: bank command code.
- `bank_dest` out 4: bank `register_Dest`.
- `privileged_mode` out 1: current mode flag, feeds the bank.
- `busy` out 1: sequencer is not IDLE.
- `timeout_error` out 1: sticky timeout flag; driven 0 when the timeout feature is compiled out.

## Operation
- States: IDLE, LOAD_WAIT, LOAD_COMMIT.
- `wb_ready` = (state == IDLE). A request is accepted when `wb_valid && wb_ready`.
- Accepted request in IDLE, by kind. Outputs appear in the following cycle.
  - ALU: enable=1, control=1, dest=`wb_dest`; stay in IDLE.
  - LOAD_DIRECT: enable=1, control=6; stay in IDLE.
  - LOAD: enable=1, control=3, dest=`wb_dest`; go to LOAD_WAIT.
  - TRAP: enable=1, control=4; set `privileged_mode`.
  - RETURN: enable=1, control=0; clear `privileged_mode`.
  - SOFT_RESET: enable=1, control=2; clear `privileged_mode`.
  - NONE and illegal (7): enable=1, control=0, so the PC/SP still advance.
- No accepted request: enable=0, control=0.
- LOAD_WAIT: enable=0. When `mem_ack`=1, go to LOAD_COMMIT.
- LOAD_COMMIT: enable=1, control=5, dest held; return to IDLE.
- `bank_dest` holds its last value whenever it is not updated.
- Destination 14 or 15 with LOAD: the sequence still runs fully. The bank suppresses the write; the sequencer performs no filtering.
- `wb_valid` while busy is ignored. The decoder must hold the request until `wb_ready`.

## Timing
- Reset values: state IDLE, `bank_enable`=0, `bank_control`=0, `bank_dest`=0, `privileged_mode`=0, `busy`=0, `timeout_error`=0, timeout counter 0.
- Outputs change on posedge and are stable through the following negedge, where the bank samples them.
- ALU / LOAD_DIRECT / TRAP / RETURN / SOFT_RESET: one-cycle latency from acceptance to command.
- LOAD:
  - Acceptance in cycle N gives code 3 in cycle N+1.
  - The earliest `mem_ack` is sampled at the posedge ending cycle N+1.
  - Code 5 appears in the cycle after the `mem_ack` cycle, so the bank's buffer has already captured the data.
  - Minimum 3 cycles from acceptance to return to IDLE.
- `mem_ack` outside LOAD_WAIT is ignored.
- Reset asserted mid-LOAD:
  - Abort immediately to IDLE with outputs at their reset values.
  - No code 5 is issued.
  - `timeout_error` is cleared.

## Configuration
- `REGBANK_SEQ_TIMEOUT_EN` defined:
  - An 8-bit counter counts LOAD_WAIT cycles.
  - When the count reaches `TIMEOUT_CYCLES` without `mem_ack`: set `timeout_error` (sticky until reset), return to IDLE, and issue no code 5.
  - `mem_ack` in the same cycle as the limit wins: normal commit, no error.
- `REGBANK_SEQ_TIMEOUT_EN` undefined: LOAD_WAIT waits indefinitely, and `timeout_error` is tied to 0.

## Structure
- Shared package `armaria_regbank_pkg`:
  - `wb_kind_t` enum.
  - Bank command constants CTRL_NONE=0, CTRL_ALU=1, CTRL_SOFT_RESET=2, CTRL_LOAD_CAPTURE=3, CTRL_ENTER_PRIV=4, CTRL_LOAD_COMMIT=5, CTRL_LOAD_DIRECT=6.
  - Sequencer state enum.
- One sub-module, `load_timeout_counter`, instantiated only under `REGBANK_SEQ_TIMEOUT_EN`. Ports: clear, count, limit, expired.

## Test plan
- ALU write: accept ALU with dest=3 → the next cycle shows enable=1, control=1, dest=3; `wb_ready` stays 1.
- Buffered load: accept LOAD with dest=5, then `mem_ack` 4 cycles later →
  - control=3 for one cycle;
  - enable=0 for 4 cycles;
  - control=5 with dest=5 for one cycle;
  - `busy` low afterwards.
- Trap then return: TRAP → control=4 and `privileged_mode`=1; RETURN → control=0 and `privileged_mode`=0.
- Backpressure: assert `wb_valid` with ALU during LOAD_WAIT → `wb_ready`=0 and no control=1 until after the commit.
- Reset mid-load: reset in LOAD_WAIT, then `mem_ack` → no control=5; state IDLE, all outputs 0.
- Timeout (macro on, `TIMEOUT_CYCLES`=15): LOAD with no ack → `timeout_error`=1 after 15 wait cycles, no control=5, `wb_ready`=1.
